// File: rtl/csr_inst_queue.sv
// CSR instruction queue: write side of a gray-pointer CDC queue.
// Dispatch writes entries here, and CSR issue reads the flattened entries in its own clock domain.
module csr_inst_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IW    = 113,
  parameter int unsigned SYNC  = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [IW-1:0]             i_inst,
  input  logic                      i_flush,
  input  logic [$clog2(DEPTH):0]    i_rd_gray,
  output logic [DEPTH*IW-1:0]       o_entries,
  output logic [$clog2(DEPTH):0]    o_wr_gray,
  output logic                      o_full,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] r_wr_bin;
  logic [PW-1:0] r_wr_gray;
  logic [PW-1:0] r_sync [SYNC];
  logic [IW-1:0] r_mem  [DEPTH];
  logic          r_overflow;

  logic [PW-1:0] w_rd_gray_s;
  logic [PW-1:0] w_rd_bin_s;
  logic [PW-1:0] w_wr_bin_nxt;
  logic          w_full;
  logic          w_handshake;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int i = 0; i < PW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // Decode the synchronized read pointer and derive flags and handshake.
  always_comb begin
    w_rd_gray_s  = r_sync[SYNC-1];
    w_rd_bin_s   = gray2bin(w_rd_gray_s);
    w_wr_bin_nxt = r_wr_bin + PW'(1);
    w_full       = (r_wr_gray == {~w_rd_gray_s[PW-1:PW-2], w_rd_gray_s[PW-3:0]});
    w_handshake  = i_valid & ~w_full & ~i_flush;
  end

  // Write pointer in binary and gray. A flush rewinds it to the consumer position.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_bin  <= '0;
      r_wr_gray <= '0;
    end else if (i_flush) begin
      r_wr_bin  <= w_rd_bin_s;
      r_wr_gray <= bin2gray(w_rd_bin_s);
    end else if (w_handshake) begin
      r_wr_bin  <= w_wr_bin_nxt;
      r_wr_gray <= bin2gray(w_wr_bin_nxt);
    end
  end

  // Read-pointer synchronizer chain from the CSR issue domain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_rd_gray;
      for (int i = 1; i < SYNC; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Entry storage. The entry is written on the same edge that advances the gray pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (w_handshake) begin
      r_mem[r_wr_bin[AW-1:0]] <= i_inst;
    end
  end

  // Sticky overflow flag: dispatch offered an instruction while the queue was full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
    end else if (i_valid && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  // Flatten the entries and drive the status outputs.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      o_entries[k*IW +: IW] = r_mem[k];
    end
    o_wr_gray  = r_wr_gray;
    o_full     = w_full;
    o_count    = r_wr_bin - w_rd_bin_s;
    o_ready    = ~w_full & ~i_flush;
    o_overflow = r_overflow;
  end

endmodule

// File: tb/tb_csr_inst_queue.sv
// Self-checking bench for csr_inst_queue. It uses directed scenarios plus a random
// dispatch/consume/flush mix, and checks the DUT against a pointer/array reference model.
module tb_csr_inst_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IW    = 113;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned PW    = 5;
  localparam int          MODN  = 2 * DEPTH;

  logic                clk;
  logic                rstn;
  logic                i_valid;
  logic                o_ready;
  logic [IW-1:0]       i_inst;
  logic                i_flush;
  logic [PW-1:0]       i_rd_gray;
  logic [DEPTH*IW-1:0] o_entries;
  logic [PW-1:0]       o_wr_gray;
  logic                o_full;
  logic [PW-1:0]       o_count;
  logic                o_overflow;

  csr_inst_queue #(.DEPTH(DEPTH), .IW(IW), .SYNC(SYNC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_inst     (i_inst),
    .i_flush    (i_flush),
    .i_rd_gray  (i_rd_gray),
    .o_entries  (o_entries),
    .o_wr_gray  (o_wr_gray),
    .o_full     (o_full),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model: write count, consumer position as seen by the writer, and stored words.
  logic [IW-1:0] mdl_mem [DEPTH];
  int            mdl_wr;
  int            mdl_rd;
  bit            mdl_ovf;

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int mdl_count();
    return (mdl_wr - mdl_rd + MODN) % MODN;
  endfunction

  function automatic bit mdl_full();
    return mdl_count() == DEPTH;
  endfunction

  function automatic logic [IW-1:0] rnd_inst();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[IW-1:0];
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_gray"},  128'(o_wr_gray),  128'(gray(mdl_wr)));
    check({tag, "_count"}, 128'(o_count),    128'(mdl_count()));
    check({tag, "_full"},  128'(o_full),     128'(mdl_full()));
    check({tag, "_ovf"},   128'(o_overflow), 128'(mdl_ovf));
  endtask

  task automatic check_entries(input string tag);
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("%s_e%0d", tag, k), 128'(o_entries[k*IW +: IW]), 128'(mdl_mem[k]));
    end
  endtask

  task automatic mdl_clear();
    for (int k = 0; k < DEPTH; k++) mdl_mem[k] = '0;
    mdl_wr  = 0;
    mdl_rd  = 0;
    mdl_ovf = 0;
  endtask

  // One clock cycle. It is called at a negedge and returns at the next negedge.
  task automatic cycle(input bit v, input logic [IW-1:0] d, input bit fl);
    bit full_before;
    i_valid = v;
    i_inst  = d;
    i_flush = fl;
    #1;
    full_before = mdl_full();
    check("ready", 128'(o_ready), 128'(!full_before && !fl));
    @(posedge clk);
    if (v && full_before) mdl_ovf = 1;
    if (fl) begin
      mdl_wr = mdl_rd;
    end else if (v && !full_before) begin
      mdl_mem[mdl_wr % DEPTH] = d;
      mdl_wr = (mdl_wr + 1) % MODN;
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_flush = 1'b0;
    check_state("cyc");
  endtask

  // The consumer moves to binary position b. The writer sees it after the synchronizer latency.
  task automatic set_rd(input int b);
    i_rd_gray = gray(b);
    repeat (SYNC) @(negedge clk);
    mdl_rd = b;
    check_state("rdsync");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn      = 1'b0;
    i_valid   = 1'b0;
    i_flush   = 1'b0;
    i_rd_gray = '0;
    mdl_clear();
    #1;
    check("rst_ready", 128'(o_ready), 128'(1));
    check_state("rst");
    check_entries("rst");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [IW-1:0] x;
    n_checks  = 0;
    n_fail    = 0;
    rstn      = 1'b0;
    i_valid   = 1'b0;
    i_inst    = '0;
    i_flush   = 1'b0;
    i_rd_gray = '0;
    mdl_clear();

    // Three writes after reset
    do_reset();
    cycle(1, IW'(1), 0);
    cycle(1, IW'(2), 0);
    cycle(1, IW'(3), 0);
    check("w3_e0", 128'(o_entries[0*IW +: IW]), 128'(1));
    check("w3_e1", 128'(o_entries[1*IW +: IW]), 128'(2));
    check("w3_e2", 128'(o_entries[2*IW +: IW]), 128'(3));
    check("w3_gray", 128'(o_wr_gray), 128'(5'b00010));
    check("w3_count", 128'(o_count), 128'(3));

    // Fill to full, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, IW'(i + 1), 0);
    check("fill_full", 128'(o_full), 128'(1));
    check("fill_ready", 128'(o_ready), 128'(0));
    cycle(1, IW'(32'hDEAD), 0);
    check("ovf_flag", 128'(o_overflow), 128'(1));
    check("ovf_e0", 128'(o_entries[0*IW +: IW]), 128'(1));

    // Full deasserts exactly SYNC edges after the consumer moves
    i_rd_gray = 5'b00001;
    @(posedge clk);
    @(negedge clk);
    check("sync_full_e1", 128'(o_full), 128'(1));
    @(posedge clk);
    @(negedge clk);
    check("sync_full_e2", 128'(o_full), 128'(0));
    check("sync_count", 128'(o_count), 128'(15));
    mdl_rd = 1;
    check_entries("sync");

    // 40 writes with a tracking consumer; pointer and index wrap
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cycle(1, IW'(i + 1), 0);
      if (mdl_wr == 31) check("wrap_g31", 128'(o_wrap_gray_dummy()), 128'(5'b10000));
      if (mdl_wr == 0)  check("wrap_g0",  128'(o_wr_gray), 128'(5'b00000));
      if (i % 8 == 7) set_rd(mdl_wr);
    end
    check("wrap_e15", 128'(o_entries[15*IW +: IW]), 128'(32));
    check("wrap_e0",  128'(o_entries[0*IW +: IW]),  128'(33));
    check_entries("wrap");

    // Flush rewinds to the consumer and writes nothing
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, rnd_inst(), 0);
    set_rd(2);
    cycle(1, rnd_inst(), 1);
    check("flush_gray", 128'(o_wr_gray), 128'(5'b00011));
    check("flush_count", 128'(o_count), 128'(0));
    check_entries("flush");

    // Asynchronous reset between edges during a write
    @(negedge clk);
    i_valid = 1'b1;
    i_inst  = rnd_inst();
    #2;
    rstn = 1'b0;
    mdl_clear();
    #1;
    check("arst_ready", 128'(o_ready), 128'(1));
    check_state("arst");
    check_entries("arst");
    i_valid   = 1'b0;
    i_rd_gray = '0;
    @(negedge clk);
    rstn = 1'b1;
    x = rnd_inst();
    cycle(1, x, 0);
    check("arst_first_e0", 128'(o_entries[0*IW +: IW]), 128'(x));
    check("arst_first_count", 128'(o_count), 128'(1));

    // Randomized dispatch / consume / flush
    for (int it = 0; it < 400; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8 && mdl_count() > 0) begin
        set_rd((mdl_rd + int'($urandom_range(1, mdl_count()))) % MODN);
      end else if (r < 12) begin
        cycle(1'($urandom_range(0, 1)), rnd_inst(), 1);
      end else begin
        cycle($urandom_range(0, 99) < 75, rnd_inst(), 0);
      end
      if (it % 50 == 49) check_entries("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [PW-1:0] o_wrap_gray_dummy();
    return o_wr_gray;
  endfunction

endmodule

// File: doc/csr_inst_queue.md
CSR_INST_QUEUE -- requirements
Module: csr_inst_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of instruction entries (power of two).
REQ-002 The block SHALL have parameter IW, default 113, meaning the width of one CSR instruction word.
REQ-003 The block SHALL have parameter SYNC, default 2, meaning the number of flops in the read-pointer synchronizer.
REQ-004 The block SHALL have port clk, input, 1, meaning the write-domain clock.
REQ-005 The block SHALL have port rstn, input, 1, meaning reset: asynchronous, active-low.
REQ-006 The block SHALL have port i_valid, input, 1, meaning the dispatch stage offers an instruction.
REQ-007 The block SHALL have port o_ready, output, 1, meaning the queue accepts an instruction this cycle.
REQ-008 The block SHALL have port i_inst, input, IW, meaning the CSR instruction word.
REQ-009 The block SHALL have port i_flush, input, 1, meaning discard all unread entries.
REQ-010 The block SHALL have port i_rd_gray, input, log2(DEPTH)+1, meaning the CSR issue stage read pointer, gray-coded and asynchronous to clk.
REQ-011 The block SHALL have port o_entries, output, DEPTH*IW, meaning all entries flattened, with entry k at bits [k*IW +: IW].
REQ-012 The block SHALL have port o_wr_gray, output, log2(DEPTH)+1, meaning the registered gray write pointer consumed by CSR issue.
REQ-013 The block SHALL have port o_full, output, 1, meaning the queue is full.
REQ-014 The block SHALL have port o_count, output, log2(DEPTH)+1, meaning the occupancy as seen from the write side.
REQ-015 The block SHALL have port o_overflow, output, 1, meaning a sticky flag set by i_valid while full.

Function
REQ-016 The block SHALL treat a write handshake as i_valid & o_ready sampled at the rising edge of clk.
REQ-017 On a handshake, the block SHALL store i_inst into entry wr_bin[log2(DEPTH)-1:0] and increment wr_bin modulo 2*DEPTH at the same edge.
REQ-018 The block SHALL drive o_wr_gray as a register equal to wr_bin ^ (wr_bin >> 1), updated on the same edge as the entry write, so that data is stable for at least SYNC cycles before the consumer observes the pointer.
REQ-019 The block SHALL pass i_rd_gray through SYNC flops to form rd_gray_s, then convert it to binary rd_bin_s by prefix XOR from the MSB.
REQ-020 The block SHALL assert o_full when wr_gray equals rd_gray_s with its two MSBs inverted and all other bits equal.
REQ-021 The block SHALL compute o_count as (wr_bin - rd_bin_s) modulo 2*DEPTH, so that 0 ≤ o_count ≤ DEPTH.
REQ-022 The block SHALL drive o_ready = !o_full & !i_flush combinationally.
REQ-023 The block SHALL set o_overflow when i_valid & o_full at a clock edge, and hold it until reset.
REQ-024 When i_flush is high at an edge, the block SHALL load rd_bin_s into wr_bin and its gray code into o_wr_gray, and SHALL NOT accept or write any entry.
REQ-025 The caller SHALL assert i_flush only while CSR issue is idle; entry contents SHALL be unchanged by a flush.
REQ-026 Pointer wrap from 2*DEPTH-1 to 0 SHALL be seamless, with exactly one gray bit toggling.
REQ-027 Because of the synchronizer, the block SHALL deassert o_full no earlier than SYNC edges after i_rd_gray changes.

Reset
REQ-028 On rstn low, wr_bin, o_wr_gray, all synchronizer flops, o_count, o_overflow and all entries SHALL be 0, o_full SHALL be 0 and o_ready SHALL be 1, independent of clk.
REQ-029 Reset asserted mid-write SHALL discard the in-flight instruction, and the first edge after release SHALL behave as an empty queue.

Verification
REQ-030 The bench SHALL check: reset, then 3 writes of 0x1, 0x2, 0x3 -> entries 0..2 hold those values, o_wr_gray = 00010, o_count = 3.
REQ-031 The bench SHALL check: 16 writes with i_rd_gray = 0 -> o_full = 1 and o_ready = 0 after the 16th; a 17th i_valid -> o_overflow = 1 and entry 0 unchanged.
REQ-032 The bench SHALL check: with the queue full, set i_rd_gray = 00001 -> o_full drops exactly 2 edges later and o_count = 15.
REQ-033 The bench SHALL check: 40 writes with the consumer tracking -> wr_bin wraps 31->0, o_wr_gray goes 10000 -> 00000, and entry index wraps 15->0.
REQ-034 The bench SHALL check: 5 writes, consumer at 2, then i_flush with i_valid high -> o_wr_gray = gray(2) = 00011, o_count = 0, and no entry written.
REQ-035 The bench SHALL check: rstn pulsed low between clock edges during a write -> all outputs 0 immediately and o_ready = 1.
